// File: rtl/bp_coh_wh_link_arbiter.sv
// Wormhole arbiter: shares one coherence NoC injection link among els_p ready-and
// flit sources, holding the grant for a whole packet and rotating round-robin.
module bp_coh_wh_link_arbiter #(
  parameter int els_p        = 2,
  parameter int flit_width_p = 64,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [els_p*flit_width_p-1:0]   in_data_i,
  input  logic [els_p-1:0]                in_v_i,
  output logic [els_p-1:0]                in_ready_and_o,
  output logic [flit_width_p-1:0]         out_data_o,
  output logic                            out_v_o,
  input  logic                            out_ready_and_i,
  output logic [els_p-1:0]                grant_o,
  output logic                            lock_o
);

  localparam int IDX_W = $clog2(els_p);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e                                 r_state, w_state_nxt;
  logic [IDX_W-1:0]                       r_rr_ptr, w_rr_nxt;
  logic [IDX_W-1:0]                       r_grant, w_grant_nxt;
  logic [len_width_p-1:0]                 r_len_cnt, w_len_nxt;
  logic [IDX_W-1:0]                       w_pick, w_sel;
  logic                                   w_pick_v, w_active, w_xfer;
  logic [len_width_p-1:0]                 w_hdr_len;
  logic [els_p-1:0][flit_width_p-1:0]     w_data;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= els_p) s = s - els_p;
    return s[IDX_W-1:0];
  endfunction

  // Scan farthest-to-nearest from rr_ptr so the nearest valid source is the last write.
  always_comb begin
    w_pick_v = 1'b0;
    w_pick   = r_rr_ptr;
    for (int k = els_p-1; k >= 0; k--) begin
      if (in_v_i[wrap_add(r_rr_ptr, k)]) begin
        w_pick_v = 1'b1;
        w_pick   = wrap_add(r_rr_ptr, k);
      end
    end
  end

  assign w_data     = in_data_i;
  assign w_sel      = (r_state == BURST) ? r_grant : w_pick;
  assign w_active   = reset_n_i & ((r_state == BURST) | w_pick_v);
  assign out_v_o    = reset_n_i & ((r_state == BURST) ? in_v_i[r_grant] : w_pick_v);
  assign out_data_o = w_data[w_sel];
  assign w_hdr_len  = out_data_o[len_offset_p +: len_width_p];
  assign w_xfer     = out_v_o & out_ready_and_i;
  assign lock_o     = (r_state == BURST);

  for (genvar g = 0; g < els_p; g++) begin : g_src
    assign grant_o[g]        = w_active & (w_sel == IDX_W'(g));
    assign in_ready_and_o[g] = out_ready_and_i & grant_o[g];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_grant_nxt = r_grant;
    w_len_nxt   = r_len_cnt;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          if (w_hdr_len != '0) begin
            w_state_nxt = BURST;
            w_len_nxt   = w_hdr_len;
            w_grant_nxt = w_pick;
          end else begin
            w_rr_nxt = wrap_add(w_pick, 1);
          end
        end
      end
      BURST: begin
        if (w_xfer) begin
          w_len_nxt = r_len_cnt - 1'b1;
          if (r_len_cnt == len_width_p'(1)) begin
            w_state_nxt = IDLE;
            w_rr_nxt    = wrap_add(r_grant, 1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_len_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_grant   <= w_grant_nxt;
      r_len_cnt <= w_len_nxt;
    end
  end

endmodule

// File: tb/tb_bp_coh_wh_link_arbiter.sv
// Bench for bp_coh_wh_link_arbiter: directed scenarios plus randomized packet traffic
// scored against a packet-level round-robin model.
module tb_bp_coh_wh_link_arbiter;
  localparam int N  = 2;
  localparam int W  = 64;
  localparam int LW = 4;
  localparam int LO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_v, in_ready, grant;
  logic [W-1:0]     out_data;
  logic             out_v, out_ready, lock;

  logic [3*W-1:0]   in_data3;
  logic [2:0]       in_v3, in_ready3, grant3;
  logic [W-1:0]     out_data3;
  logic             out_v3, out_ready3, lock3;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] fl [N][256];
  int           wr [N];
  int           rd [N];

  bp_coh_wh_link_arbiter #(.els_p(N), .flit_width_p(W), .len_width_p(LW), .len_offset_p(LO)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .in_data_i(in_data), .in_v_i(in_v),
    .in_ready_and_o(in_ready), .out_data_o(out_data), .out_v_o(out_v),
    .out_ready_and_i(out_ready), .grant_o(grant), .lock_o(lock));

  bp_coh_wh_link_arbiter #(.els_p(3), .flit_width_p(W), .len_width_p(LW), .len_offset_p(LO)) dut3 (
    .clk_i(clk), .reset_n_i(rst_n), .in_data_i(in_data3), .in_v_i(in_v3),
    .in_ready_and_o(in_ready3), .out_data_o(out_data3), .out_v_o(out_v3),
    .out_ready_and_i(out_ready3), .grant_o(grant3), .lock_o(lock3));

  function automatic logic [W-1:0] mk_flit(input int len);
    logic [W-1:0] f;
    f = {$urandom, $urandom};
    f[LO +: LW] = LW'(len);
    return f;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; in_v = '0; in_v3 = '0; out_ready = 1'b0; out_ready3 = 1'b0;
    in_data = '0; in_data3 = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_v = '0; in_v3 = '0; out_ready = 1'b0; out_ready3 = 1'b0;
    in_data = '0; in_data3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL reset_out_v: got %b, want 0", out_v); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b, want 00", grant); end
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b, want 0", lock); end
    in_v = 2'b11; out_ready = 1'b1; in_data = {mk_flit(0), mk_flit(0)};
    #1;
    checks++; if ({out_v, grant, in_ready} !== 5'b0) begin
      errors++; $display("FAIL reset_forced: got v=%b g=%b rdy=%b, want all 0", out_v, grant, in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b0; in_v = 2'b10; rst_n = 1'b1;
    #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL release_grant: got %b, want 10", grant); end
    checks++; if (out_v !== 1'b1) begin errors++; $display("FAIL release_out_v: got %b, want 1", out_v); end
    @(posedge clk); #1;
    in_v = '0;
  endtask

  task automatic test_burst();
    logic [W-1:0] p [4];
    logic [W-1:0] s1;
    apply_reset();
    p[0] = mk_flit(3);
    for (int i = 1; i < 4; i++) p[i] = {$urandom, $urandom};
    s1 = mk_flit(0);
    in_v = 2'b11; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = {s1, p[i]};
      @(negedge clk);
      checks++; if (out_data !== p[i]) begin errors++; $display("FAIL burst_data[%0d]: got %h, want %h", i, out_data, p[i]); end
      checks++; if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL burst_src1_ready[%0d]: got %b, want 0", i, in_ready[1]); end
      checks++; if (lock !== (i > 0)) begin errors++; $display("FAIL burst_lock[%0d]: got %b, want %b", i, lock, (i > 0)); end
      @(posedge clk); #1;
    end
    in_v[0] = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL burst_next_grant: got %b, want 10", grant); end
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL burst_end_lock: got %b, want 0", lock); end
    @(posedge clk); #1;
    in_v = '0;
  endtask

  task automatic test_alternate();
    logic [N-1:0] exp_g;
    int           idx;
    apply_reset();
    out_ready = 1'b1; in_v = 2'b11;
    for (int k = 0; k < 6; k++) begin
      in_data = {mk_flit(0), mk_flit(0)};
      idx   = k % 2;
      exp_g = (idx == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL alt_grant[%0d]: got %b, want %b", k, grant, exp_g); end
      checks++; if (out_data !== in_data[idx*W +: W]) begin
        errors++; $display("FAIL alt_data[%0d]: got %h, want %h", k, out_data, in_data[idx*W +: W]);
      end
      @(posedge clk); #1;
    end
    in_v = '0; out_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [W-1:0] p [3];
    logic [W-1:0] s1;
    int rdy_tab [8];
    int v0_tab [8];
    int bidx, blocked, dmis;
    logic lock6, lock7;
    logic [N-1:0] grant7;
    rdy_tab = '{1, 1, 0, 0, 0, 1, 1, 1};
    v0_tab  = '{1, 0, 0, 1, 1, 1, 1, 1};
    apply_reset();
    p[0] = mk_flit(2); p[1] = {$urandom, $urandom}; p[2] = {$urandom, $urandom};
    s1 = mk_flit(0);
    bidx = 0; blocked = 0; dmis = 0; lock6 = 1'b0; lock7 = 1'b1; grant7 = '0;
    for (int c = 0; c < 8; c++) begin
      in_v      = {1'b1, (v0_tab[c] != 0) && (bidx < 3)};
      in_data   = {s1, p[(bidx < 3) ? bidx : 0]};
      out_ready = (rdy_tab[c] != 0);
      @(negedge clk);
      if (c < 7 && (grant[1] || in_ready[1])) blocked++;
      if (c == 6) lock6 = lock;
      if (c == 7) begin grant7 = grant; lock7 = lock; end
      if (out_v && out_ready && grant[0]) begin
        if (bidx > 2 || out_data !== p[bidx]) dmis++;
        bidx++;
      end
      @(posedge clk); #1;
    end
    in_v = '0; out_ready = 1'b0;
    checks++; if (bidx !== 3) begin errors++; $display("FAIL stall_xfer_count: got %0d, want 3", bidx); end
    checks++; if (dmis !== 0) begin errors++; $display("FAIL stall_data: got %0d bad flits, want 0", dmis); end
    checks++; if (blocked !== 0) begin errors++; $display("FAIL stall_src1_blocked: got %0d granted cycles, want 0", blocked); end
    checks++; if (lock6 !== 1'b1) begin errors++; $display("FAIL stall_lock_last: got %b, want 1", lock6); end
    checks++; if (grant7 !== 2'b10) begin errors++; $display("FAIL stall_next_grant: got %b, want 10", grant7); end
    checks++; if (lock7 !== 1'b0) begin errors++; $display("FAIL stall_unlock: got %b, want 0", lock7); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    in_data = {{W{1'b0}}, mk_flit(5)}; in_v = 2'b01; out_ready = 1'b1;
    @(posedge clk); #1;
    in_data = {mk_flit(0), {$urandom, $urandom}}; in_v = 2'b11; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (lock !== 1'b1) begin errors++; $display("FAIL arst_pre_lock: got %b, want 1", lock); end
    #1;
    out_ready = 1'b1; rst_n = 1'b0;
    #1;
    checks++; if (out_v !== 1'b0) begin errors++; $display("FAIL arst_out_v: got %b, want 0", out_v); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arst_grant: got %b, want 00", grant); end
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL arst_lock: got %b, want 0", lock); end
    checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL arst_ready: got %b, want 00", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b0; in_v = 2'b11; in_data = {mk_flit(0), mk_flit(0)};
    #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL arst_tie_grant: got %b, want 01", grant); end
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL arst_idle_lock: got %b, want 0", lock); end
    @(posedge clk); #1;
    in_v = '0;
  endtask

  task automatic test_els3();
    apply_reset();
    out_ready3 = 1'b1; in_v3 = 3'b001; in_data3 = {mk_flit(0), mk_flit(0), mk_flit(0)};
    @(negedge clk);
    checks++; if (grant3 !== 3'b001) begin errors++; $display("FAIL els3_first: got %b, want 001", grant3); end
    @(posedge clk); #1;
    in_v3 = 3'b101; in_data3 = {mk_flit(0), mk_flit(0), mk_flit(0)};
    @(negedge clk);
    checks++; if (grant3 !== 3'b100) begin errors++; $display("FAIL els3_rr1: got %b, want 100", grant3); end
    checks++; if (out_data3 !== in_data3[2*W +: W]) begin errors++; $display("FAIL els3_data: got %h, want %h", out_data3, in_data3[2*W +: W]); end
    @(posedge clk); #1;
    in_v3 = 3'b001;
    @(negedge clk);
    checks++; if (grant3 !== 3'b001) begin errors++; $display("FAIL els3_wrap: got %b, want 001", grant3); end
    @(posedge clk); #1;
    in_v3 = '0; out_ready3 = 1'b0;
  endtask

  task automatic test_random();
    int owner, rem, rr, src, len, r, cyc;
    bit hold [N];
    logic ev;
    logic [N-1:0] eg;
    logic [2*N+1:0] got_v, exp_v;
    for (int s = 0; s < N; s++) begin
      wr[s] = 0; rd[s] = 0; hold[s] = 1'b0;
      for (int pk = 0; pk < 12; pk++) begin
        r   = int'($urandom % 6);
        len = (r == 0) ? 0 : (r == 1) ? 15 : int'($urandom % 4);
        fl[s][wr[s]] = mk_flit(len);
        wr[s]++;
        for (int b = 0; b < len; b++) begin fl[s][wr[s]] = {$urandom, $urandom}; wr[s]++; end
      end
    end
    apply_reset();
    owner = -1; rem = 0; rr = 0; cyc = 0;
    while ((rd[0] < wr[0] || rd[1] < wr[1]) && cyc < 4000) begin
      cyc++;
      for (int s = 0; s < N; s++) begin
        if (!hold[s] && rd[s] < wr[s] && ($urandom % 4) != 0) hold[s] = 1'b1;
        in_v[s] = hold[s];
        in_data[s*W +: W] = hold[s] ? fl[s][rd[s]] : '0;
      end
      out_ready = ($urandom % 4) != 0;
      @(negedge clk);
      eg = '0; ev = 1'b0; src = 0;
      if (owner >= 0) begin
        src = owner; eg = N'(1) << owner; ev = in_v[owner];
      end else begin
        for (int k = 0; k < N; k++) begin
          if (!ev && in_v[(rr + k) % N]) begin
            src = (rr + k) % N; eg = N'(1) << src; ev = 1'b1;
          end
        end
      end
      exp_v = {eg, ev, (owner >= 0), (out_ready ? eg : {N{1'b0}})};
      got_v = {grant, out_v, lock, in_ready};
      checks++; if (got_v !== exp_v) begin
        errors++; $display("FAIL rand_ctrl[%0d]: got g/v/lock/rdy=%b, want %b", cyc, got_v, exp_v);
      end
      if (ev && out_ready) begin
        checks++; if (out_data !== fl[src][rd[src]]) begin
          errors++; $display("FAIL rand_data[%0d]: got %h, want %h", cyc, out_data, fl[src][rd[src]]);
        end
        if (owner < 0) begin
          len = int'(fl[src][rd[src]][LO +: LW]);
          if (len == 0) rr = (src + 1) % N;
          else begin owner = src; rem = len; end
        end else begin
          rem--;
          if (rem == 0) begin rr = (owner + 1) % N; owner = -1; end
        end
        rd[src]++;
        hold[src] = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_v = '0; out_ready = 1'b0;
    checks++; if (rd[0] != wr[0] || rd[1] != wr[1]) begin
      errors++; $display("FAIL rand_drain: got %0d/%0d flits sent, want %0d/%0d", rd[0], rd[1], wr[0], wr[1]);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_alternate();
    test_stall();
    test_async_reset();
    test_els3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
